phase_sequencer: RTL and testbench

Parametrised phase sequencer for the non-pipelined LEGv8 datapath. It replaces the fixed oscillator-plus-delay clock chain with single-clock, one-hot phase enables for fetch, decode-read, execute, memory and writeback. It adds a memory wait handshake, an instruction-retire counter with a run limit, and a halt request. It sits at the datapath top and drives every stage's enable.

---
 rtl/phase_sequencer_if.sv | 30 +++
 rtl/phase_sequencer.sv | 132 +++++++++++++
 tb/tb_phase_sequencer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/phase_sequencer_if.sv
// Stage-control bundle between the phase sequencer and the LEGv8 datapath stages.
// The sequencer drives the enables and status; the datapath side drives start/halt/mem_ready.
interface phase_sequencer_if #(
  parameter int NUM_PHASES = 5,
  parameter int CNT_W      = 32
);
  logic                  start;
  logic                  halt_req;
  logic                  mem_ready;
  logic [NUM_PHASES-1:0] phase_en;
  logic                  instr_done;
  logic                  mem_stall;
  logic                  busy;
  logic                  done;
  logic                  wdt_error;
  logic [CNT_W-1:0]      retired;
  logic [CNT_W-1:0]      cycles;

  // Handshake: mem_ready is a level that is only looked at while the memory phase is
  // issuing or waiting; the cycle it is seen high completes the access (no separate valid).
  modport master (
    input  start, halt_req, mem_ready,
    output phase_en, instr_done, mem_stall, busy, done, wdt_error, retired, cycles
  );

  modport slave (
    output start, halt_req, mem_ready,
    input  phase_en, instr_done, mem_stall, busy, done, wdt_error, retired, cycles
  );
endinterface

// File: rtl/phase_sequencer.sv
// One-hot phase-enable sequencer for the non-pipelined LEGv8 datapath, with memory wait,
// retire limit and halt. Optional memory-wait watchdog enabled by `define SEQ_WATCHDOG_EN.
module phase_sequencer #(
  parameter int NUM_PHASES = 5,
  parameter int MEM_PHASE  = 3,
  parameter int CNT_W      = 32,
  parameter int MAX_INSTR  = 0,
  parameter int WDT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  phase_sequencer_if.master   bus,
  output logic [1:0]          o_dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_HALT} state_t;

  localparam int              PH_W        = $clog2(NUM_PHASES);
  localparam logic [PH_W-1:0] LAST_PH     = PH_W'(NUM_PHASES - 1);
  localparam logic [PH_W-1:0] MEM_PH      = PH_W'(MEM_PHASE);
  localparam logic [PH_W-1:0] MEM_NEXT    = PH_W'(MEM_PHASE + 1);
  localparam bit              MEM_IS_LAST = (MEM_PHASE == NUM_PHASES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PH_W-1:0]  r_ph;
  logic [PH_W-1:0]  w_ph_nxt;
  logic [CNT_W-1:0] r_retired;
  logic [CNT_W-1:0] r_cycles;
  logic [CNT_W-1:0] w_ret_inc;
  logic             w_boundary;
  logic             w_stop;
  logic             w_busy;
  logic             w_timeout;

  assign w_busy    = (r_state == S_RUN) || (r_state == S_WAIT);
  assign w_ret_inc = r_retired + 1'b1;
  // Halt request and the retire limit are only honoured at an instruction boundary.
  assign w_stop    = bus.halt_req || ((MAX_INSTR != 0) && (w_ret_inc == CNT_W'(MAX_INSTR)));

  always_comb begin
    w_state_nxt = r_state;
    w_ph_nxt    = r_ph;
    w_boundary  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = S_RUN;
          w_ph_nxt    = '0;
        end
      end
      S_RUN: begin
        if ((r_ph == MEM_PH) && !bus.mem_ready) begin
          w_state_nxt = S_WAIT;
        end else if (r_ph == LAST_PH) begin
          w_boundary = 1'b1;
        end else begin
          w_ph_nxt = r_ph + 1'b1;
        end
      end
      S_WAIT: begin
        if (bus.mem_ready) begin
          if (MEM_IS_LAST) begin
            w_boundary = 1'b1;
          end else begin
            w_state_nxt = S_RUN;
            w_ph_nxt    = MEM_NEXT;
          end
        end else if (w_timeout) begin
          w_state_nxt = S_HALT;
        end
      end
      default: ;
    endcase
    if (w_boundary) begin
      w_ph_nxt    = '0;
      w_state_nxt = w_stop ? S_HALT : S_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_ph      <= '0;
      r_retired <= '0;
      r_cycles  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ph    <= w_ph_nxt;
      if (w_boundary) r_retired <= w_ret_inc;
      if (w_busy && (r_cycles != '1)) r_cycles <= r_cycles + 1'b1;
    end
  end

`ifdef SEQ_WATCHDOG_EN
  localparam int WCNT_W = $clog2(WDT_CYCLES + 1);

  logic [WCNT_W-1:0] r_wcnt;
  logic              r_wdt;
  logic              w_wait_clr;

  assign w_wait_clr = (r_state == S_RUN) && (w_state_nxt == S_WAIT);
  // r_wcnt holds the number of completed wait cycles before the current one.
  assign w_timeout  = (r_state == S_WAIT) && !bus.mem_ready && (r_wcnt == WCNT_W'(WDT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wcnt <= '0;
      r_wdt  <= 1'b0;
    end else begin
      if (w_wait_clr) r_wcnt <= '0;
      else if ((r_state == S_WAIT) && (r_wcnt != '1)) r_wcnt <= r_wcnt + 1'b1;
      if (w_timeout) r_wdt <= 1'b1;
    end
  end

  assign bus.wdt_error = r_wdt;
`else
  assign w_timeout     = 1'b0;
  assign bus.wdt_error = 1'b0;
`endif

  assign bus.phase_en   = (r_state == S_RUN) ? (NUM_PHASES'(1) << r_ph) : '0;
  assign bus.instr_done = w_boundary;
  assign bus.mem_stall  = (r_state == S_WAIT);
  assign bus.busy       = w_busy;
  assign bus.done       = (r_state == S_HALT);
  assign bus.retired    = r_retired;
  assign bus.cycles     = r_cycles;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_phase_sequencer.sv
// Scoreboard bench for phase_sequencer: a default instance and a small-counter instance
// with a retire limit of 3, both driven instruction by instruction from a reference model.
module tb_phase_sequencer;
  localparam int NP  = 5;
  localparam int MP  = 3;
  localparam int WDT = 16;
  localparam int VW  = 74;

  logic clk;
  logic s_rst[2];
  logic s_start[2];
  logic s_halt[2];
  logic s_mr[2];
  logic [1:0] dbg0, dbg1;

  phase_sequencer_if #(.NUM_PHASES(NP), .CNT_W(32)) if0 ();
  phase_sequencer_if #(.NUM_PHASES(NP), .CNT_W(4))  if1 ();

  assign if0.start = s_start[0];
  assign if0.halt_req = s_halt[0];
  assign if0.mem_ready = s_mr[0];
  assign if1.start = s_start[1];
  assign if1.halt_req = s_halt[1];
  assign if1.mem_ready = s_mr[1];

  phase_sequencer #(.NUM_PHASES(NP), .MEM_PHASE(MP), .CNT_W(32), .MAX_INSTR(0), .WDT_CYCLES(WDT)) u_dut0 (
    .clk(clk), .reset(s_rst[0]), .bus(if0), .o_dbg_state(dbg0));
  phase_sequencer #(.NUM_PHASES(NP), .MEM_PHASE(MP), .CNT_W(4), .MAX_INSTR(3), .WDT_CYCLES(WDT)) u_dut1 (
    .clk(clk), .reset(s_rst[1]), .bus(if1), .o_dbg_state(dbg1));

  wire [VW-1:0] vec0 = {if0.phase_en, if0.instr_done, if0.mem_stall, if0.busy, if0.done,
                        if0.wdt_error, if0.retired, if0.cycles};
  wire [VW-1:0] vec1 = {if1.phase_en, if1.instr_done, if1.mem_stall, if1.busy, if1.done,
                        if1.wdt_error, 28'd0, if1.retired, 28'd0, if1.cycles};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [VW-1:0] exp_q0[$];
  logic [VW-1:0] exp_q1[$];
  logic [31:0] m_ret[2];
  logic [31:0] m_cyc[2];
  logic [31:0] m_cmax[2];
  logic [31:0] m_rmask[2];
  logic [31:0] m_max[2];
  logic        m_wdt[2];

  int total = 0;
  int bad = 0;
  bit end_chk = 0;
  bit chk_done;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int wh, input logic [VW-1:0] v);
    if (wh == 0) exp_q0.push_back(v);
    else exp_q1.push_back(v);
  endtask

  // One cycle: drive inputs, record the outputs this cycle must show, advance the model.
  task automatic cyc(input int wh, input logic st, input logic hr, input logic mr,
                     input logic [NP-1:0] pe, input logic idn, input logic stl,
                     input logic bsy, input logic dn);
    s_start[wh] = st;
    s_halt[wh]  = hr;
    s_mr[wh]    = mr;
    push(wh, {pe, idn, stl, bsy, dn, m_wdt[wh], m_ret[wh], m_cyc[wh]});
    if (bsy && (m_cyc[wh] != m_cmax[wh])) m_cyc[wh] = m_cyc[wh] + 1;
    if (idn) m_ret[wh] = (m_ret[wh] + 1) & m_rmask[wh];
    step();
  endtask

  task automatic do_reset(input int wh);
    s_rst[wh] = 1'b1;
    s_start[wh] = 1'b0;
    s_halt[wh] = 1'(($urandom_range(0, 1)));
    s_mr[wh] = 1'(($urandom_range(0, 1)));
    step();
    s_rst[wh] = 1'b0;
    m_ret[wh] = 0;
    m_cyc[wh] = 0;
    m_wdt[wh] = 1'b0;
  endtask

  task automatic done_cyc(input int wh);
    cyc(wh, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
        '0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  function automatic int rand_wait();
    return ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4));
  endfunction

  // One instruction: phases 0..NP-1 in turn, w stall cycles after the memory phase.
  // hb holds halt_req from phase 1 to the boundary; abort >= 0 resets during that phase.
  task automatic run_instr(input int wh, input int w, input bit hb, input int abort,
                           output bit halted);
    logic hr;
    logic mr;
    halted = 1'b0;
    for (int p = 0; p < NP; p++) begin
      hr = hb ? (p >= 1) : ((p == NP - 1) ? 1'b0 : 1'($urandom_range(0, 1)));
      mr = (p == MP) ? (w == 0) : 1'($urandom_range(0, 1));
      if (p == abort) begin
        s_rst[wh] = 1'b1;
        cyc(wh, 1'b0, hr, mr, NP'(1 << p), 1'b0, 1'b0, 1'b1, 1'b0);
        s_rst[wh] = 1'b0;
        m_ret[wh] = 0;
        m_cyc[wh] = 0;
        m_wdt[wh] = 1'b0;
        return;
      end
      cyc(wh, 1'b0, hr, mr, NP'(1 << p), (p == NP - 1), 1'b0, 1'b1, 1'b0);
      if (p == MP) begin
        for (int k = 1; k <= w; k++) begin
          hr = hb ? 1'b1 : 1'($urandom_range(0, 1));
          cyc(wh, 1'b0, hr, (k == w), '0, 1'b0, 1'b1, 1'b1, 1'b0);
        end
      end
    end
    halted = hb || ((m_max[wh] != 0) && (m_ret[wh] == m_max[wh]));
  endtask

  task automatic seq0();
    bit h;
    do_reset(0);
    cyc(0, 1'b0, 1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(0, 1'b1, 1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) run_instr(0, 0, 1'b0, -1, h);
    run_instr(0, 3, 1'b0, -1, h);
    run_instr(0, int'($urandom_range(0, 2)), 1'b1, -1, h);
    for (int i = 0; i < 3; i++) done_cyc(0);
    // reset in phase 2 of the second instruction
    do_reset(0);
    cyc(0, 1'b1, 1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_instr(0, 1, 1'b0, -1, h);
    run_instr(0, 0, 1'b0, 2, h);
    cyc(0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int r = 0; r < 6; r++) begin
      do_reset(0);
      cyc(0, 1'b1, 1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      h = 1'b0;
      for (int i = 0; i < 8 && !h; i++)
        run_instr(0, rand_wait(), (i == 7) || ($urandom_range(0, 5) == 0), -1, h);
      done_cyc(0);
      done_cyc(0);
    end
`ifdef SEQ_WATCHDOG_EN
    do_reset(0);
    cyc(0, 1'b1, 1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_instr(0, 0, 1'b0, -1, h);
    for (int p = 0; p <= MP; p++)
      cyc(0, 1'b0, 1'b0, (p != MP), NP'(1 << p), 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < WDT; k++)
      cyc(0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    m_wdt[0] = 1'b1;
    for (int i = 0; i < 3; i++) done_cyc(0);
`endif
  endtask

  task automatic seq1();
    bit h;
    int n;
    do_reset(1);
    cyc(1, 1'b1, 1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_instr(1, 4, 1'b0, -1, h);
    n = 0;
    while (!h && n < 6) begin
      run_instr(1, rand_wait(), 1'b0, -1, h);
      n++;
    end
    for (int i = 0; i < 4; i++) done_cyc(1);
    // halt request on the same boundary that reaches the retire limit
    do_reset(1);
    cyc(1, 1'b1, 1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_instr(1, 0, 1'b0, -1, h);
    run_instr(1, 0, 1'b0, -1, h);
    run_instr(1, 2, 1'b1, -1, h);
    for (int i = 0; i < 3; i++) done_cyc(1);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin : monitor
    logic [VW-1:0] e;
    if (exp_q0.size() != 0) begin
      e = exp_q0.pop_front();
      total++;
      if (vec0 !== e) begin
        bad++;
        $display("FAIL dut0_outputs t=%0t act=%h exp=%h", $time, vec0, e);
      end
    end
    if (exp_q1.size() != 0) begin
      e = exp_q1.pop_front();
      total++;
      if (vec1 !== e) begin
        bad++;
        $display("FAIL dut1_outputs t=%0t act=%h exp=%h", $time, vec1, e);
      end
    end
    if (end_chk && !chk_done) begin
      total++;
      if (exp_q0.size() + exp_q1.size() != 0) begin
        bad++;
        $display("FAIL queue_drain act=%0d exp=0", exp_q0.size() + exp_q1.size());
      end
      chk_done = 1'b1;
    end
  end

  initial begin
    m_cmax[0] = 32'hFFFF_FFFF; m_rmask[0] = 32'hFFFF_FFFF; m_max[0] = 0;
    m_cmax[1] = 32'hF;         m_rmask[1] = 32'hF;         m_max[1] = 3;
    for (int i = 0; i < 2; i++) begin
      s_rst[i] = 1'b1; s_start[i] = 1'b0; s_halt[i] = 1'b0; s_mr[i] = 1'b0;
      m_ret[i] = 0; m_cyc[i] = 0; m_wdt[i] = 1'b0;
    end
    step();
    fork
      seq0();
      seq1();
    join
    step();
    end_chk = 1'b1;
    wait (chk_done);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "bench timeout");
  end
endmodule
